// File: rtl/soc_system_ocram_arb_pkg.sv
// Shared types and default widths for the on-chip RAM arbiter.
package soc_system_ocram_arb_pkg;

    localparam int unsigned OCRAM_ADDR_W = 12;
    localparam int unsigned OCRAM_DATA_W = 32;
    localparam int unsigned OCRAM_BE_W   = OCRAM_DATA_W / 8;

    typedef enum logic {
        PORT_S0 = 1'b0,
        PORT_S1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/soc_system_rr_arb2.sv
// Two-way per-cycle arbiter: fixed priority or round-robin with a last-grant register.
module soc_system_rr_arb2
    import soc_system_ocram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       block,
    output logic [1:0] gnt
);

    port_id_t last_grant;

    // Combinational grant; on contention the port that did not win last time goes first.
    always_comb begin
        gnt = '0;
        if (!block) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (fixed_prio || (last_grant == PORT_S1))
                        gnt = 2'b01;
                    else
                        gnt = 2'b10;
                end
                default: gnt = '0;
            endcase
        end
    end

    // Remember the most recent winner; reset to s1 so s0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= PORT_S1;
        else if (gnt[0])
            last_grant <= PORT_S0;
        else if (gnt[1])
            last_grant <= PORT_S1;
    end

endmodule

// File: rtl/soc_system_ocram_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM requesters.
module soc_system_ocram_arbiter
    import soc_system_ocram_arb_pkg::*;
#(
    parameter  int unsigned ADDR_W     = OCRAM_ADDR_W,
    parameter  int unsigned DATA_W     = OCRAM_DATA_W,
    parameter  int unsigned FIXED_PRIO = 0,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [CNT_W-1:0]  contention_count
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] rd_vld;
    logic       block;

    assign req   = {s1_read | s1_write, s0_read | s0_write};
    assign block = reset | reset_req;

    soc_system_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (reset),
        .req        (req),
        .fixed_prio (FIXED_PRIO != 0),
        .block      (block),
        .gnt        (gnt)
    );

    assign s0_waitrequest = ~gnt[0];
    assign s1_waitrequest = ~gnt[1];

    // Route the granted port's command onto the RAM; drive zeros when idle.
    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (gnt[0]) begin
            ram_chipselect = 1'b1;
            ram_write      = s0_write;
            ram_address    = s0_address;
            ram_byteenable = s0_byteenable;
            ram_writedata  = s0_writedata;
        end else if (gnt[1]) begin
            ram_chipselect = 1'b1;
            ram_write      = s1_write;
            ram_address    = s1_address;
            ram_byteenable = s1_byteenable;
            ram_writedata  = s1_writedata;
        end
    end

    // Read-return tag: one flop per port (valid + port id decoded at the edge) so each
    // readdatavalid comes straight from a register and cannot glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_vld <= '0;
        else
            rd_vld <= {gnt[1] & ~s1_write, gnt[0] & ~s0_write};
    end

    assign s0_readdatavalid = rd_vld[0];
    assign s1_readdatavalid = rd_vld[1];
    assign s0_readdata      = ram_readdata;
    assign s1_readdata      = ram_readdata;

    // Saturating count of cycles where both ports request while grants are allowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            contention_count <= '0;
        else if ((&req) && !reset_req && (contention_count != '1))
            contention_count <= contention_count + 1'b1;
    end

endmodule

// File: tb/tb_soc_system_ocram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus; each has
// its own RAM behind it and its own reference model.
module tb_soc_system_ocram_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_req = 1'b0;
    logic [11:0] s0_address = '0, s1_address = '0;
    logic [3:0]  s0_byteenable = '0, s1_byteenable = '0;
    logic        s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [31:0] s0_writedata = '0, s1_writedata = '0;

    logic        w0 [2];
    logic        w1 [2];
    logic        rdv0 [2];
    logic        rdv1 [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [11:0] ram_a [2];
    logic [3:0]  ram_be [2];
    logic        ram_cs [2];
    logic        ram_we [2];
    logic [31:0] ram_wd [2];
    logic [31:0] ram_rd [2];
    logic [15:0] cnt [2];

    logic [31:0] env_mem [2][4096];
    logic [31:0] ref_mem [2][4096];
    int          last_win [2];
    int          exp_cnt [2];
    exp_t        q_rr[$];
    exp_t        q_fp[$];
    logic        rst_next = 1'b1;
    logic        rstm = 1'b1;
    int          cycn = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycn <= cycn + 1;

    soc_system_ocram_arbiter #(.ADDR_W(12), .DATA_W(32), .FIXED_PRIO(0), .CNT_W(16)) dut_rr (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(w0[0]),
        .s0_readdata(rd0[0]), .s0_readdatavalid(rdv0[0]),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(w1[0]),
        .s1_readdata(rd1[0]), .s1_readdatavalid(rdv1[0]),
        .ram_address(ram_a[0]), .ram_byteenable(ram_be[0]), .ram_chipselect(ram_cs[0]),
        .ram_write(ram_we[0]), .ram_writedata(ram_wd[0]), .ram_readdata(ram_rd[0]),
        .contention_count(cnt[0])
    );

    soc_system_ocram_arbiter #(.ADDR_W(12), .DATA_W(32), .FIXED_PRIO(1), .CNT_W(16)) dut_fp (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(w0[1]),
        .s0_readdata(rd0[1]), .s0_readdatavalid(rdv0[1]),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(w1[1]),
        .s1_readdata(rd1[1]), .s1_readdatavalid(rdv1[1]),
        .ram_address(ram_a[1]), .ram_byteenable(ram_be[1]), .ram_chipselect(ram_cs[1]),
        .ram_write(ram_we[1]), .ram_writedata(ram_wd[1]), .ram_readdata(ram_rd[1]),
        .contention_count(cnt[1])
    );

    // RAM models behind each instance: byte-enabled write, 1-cycle registered read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_cs[k]) begin
                if (ram_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be[k][b]) env_mem[k][ram_a[k]][8*b +: 8] <= ram_wd[k][8*b +: 8];
                end else begin
                    ram_rd[k] <= env_mem[k][ram_a[k]];
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d actual=%0h required=%0h", name, k, cycn, act, exp);
        end
    endtask

    // Monitor: pop the expected read return due this cycle and compare.
    task automatic mon(input int k);
        exp_t it;
        logic have;
        have = 1'b0;
        it.port = 0; it.data = '0; it.due = 0;
        if (k == 0) begin
            if (q_rr.size() != 0 && q_rr[0].due == cycn) begin it = q_rr.pop_front(); have = 1'b1; end
        end else begin
            if (q_fp.size() != 0 && q_fp[0].due == cycn) begin it = q_fp.pop_front(); have = 1'b1; end
        end
        chk("rdv0", k, {31'b0, rdv0[k]}, {31'b0, have && it.port == 0});
        chk("rdv1", k, {31'b0, rdv1[k]}, {31'b0, have && it.port == 1});
        if (have) chk("rdata", k, (it.port == 0) ? rd0[k] : rd1[k], it.data);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // One command cycle: drive at the falling edge, predict grants from the model, check.
    task automatic cyc_drive(input logic r0, input logic wr0, input logic [11:0] a0,
                             input logic [3:0] b0, input logic [31:0] d0,
                             input logic r1, input logic wr1, input logic [11:0] a1,
                             input logic [3:0] b1, input logic [31:0] d1, input logic rq);
        int          g;
        logic        q0, q1, blk;
        logic        gw;
        logic [11:0] ga;
        logic [3:0]  gb;
        logic [31:0] gd;
        exp_t        e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("count", k, {16'b0, cnt[k]}, exp_cnt[k]);
        reset = rst_next; rstm = rst_next; reset_req = rq;
        s0_read = r0; s0_write = wr0; s0_address = a0; s0_byteenable = b0; s0_writedata = d0;
        s1_read = r1; s1_write = wr1; s1_address = a1; s1_byteenable = b1; s1_writedata = d1;
        #1;
        q0 = r0 | wr0; q1 = r1 | wr1; blk = rstm | rq;
        for (int k = 0; k < 2; k++) begin
            g = -1;
            if (!blk) begin
                if (q0 && q1) g = (k == 1) ? 0 : 1 - last_win[k];
                else if (q0) g = 0;
                else if (q1) g = 1;
            end
            chk("wait0", k, {31'b0, w0[k]}, {31'b0, g != 0});
            chk("wait1", k, {31'b0, w1[k]}, {31'b0, g != 1});
            chk("chipselect", k, {31'b0, ram_cs[k]}, {31'b0, g >= 0});
            if (g >= 0) begin
                last_win[k] = g;
                gw = (g == 0) ? wr0 : wr1;
                ga = (g == 0) ? a0 : a1;
                gb = (g == 0) ? b0 : b1;
                gd = (g == 0) ? d0 : d1;
                if (gw) begin
                    for (int b = 0; b < 4; b++) if (gb[b]) ref_mem[k][ga][8*b +: 8] = gd[8*b +: 8];
                end else begin
                    e.port = g; e.data = ref_mem[k][ga]; e.due = cycn + 1;
                    if (k == 0) q_rr.push_back(e); else q_fp.push_back(e);
                end
            end
            if (q0 && q1 && !blk && exp_cnt[k] < 65535) exp_cnt[k]++;
        end
    endtask

    task automatic idle(input logic rq);
        cyc_drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, rq);
    endtask

    // Asynchronous reset shortly after a rising edge, before any return can be sampled.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        reset = 1'b1; rstm = 1'b1; rst_next = 1'b1;
        q_rr.delete(); q_fp.delete();
        for (int k = 0; k < 2; k++) begin last_win[k] = 1; exp_cnt[k] = 0; end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            last_win[k] = 1; exp_cnt[k] = 0; ram_rd[k] = '0;
            for (int i = 0; i < 4096; i++) begin
                env_mem[k][i] = (i * 32'h9E3779B1) ^ 32'h5A5A_0000;
                ref_mem[k][i] = (i * 32'h9E3779B1) ^ 32'h5A5A_0000;
            end
        end
        // Reset state, with requests pending that must not be granted.
        idle(0);
        cyc_drive(1, 0, 12'h001, 4'hF, '0, 1, 0, 12'h002, 4'hF, '0, 0);
        rst_next = 1'b0;
        // s0 write then read back.
        cyc_drive(0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0, '0, '0, '0, 0);
        cyc_drive(1, 0, 12'h010, 4'hF, '0, 0, 0, '0, '0, '0, 0);
        idle(0);
        // Continuous contention, six cycles.
        for (int i = 0; i < 6; i++)
            cyc_drive(1, 0, 12'(i), 4'hF, '0, 1, 0, 12'(100 + i), 4'hF, '0, 0);
        idle(0);
        // s1 partial write then read: upper bytes keep their old value.
        cyc_drive(0, 0, '0, '0, '0, 0, 1, 12'h020, 4'h3, 32'hAABBCCDD, 0);
        cyc_drive(0, 0, '0, '0, '0, 1, 0, 12'h020, 4'hF, '0, 0);
        // read+write together behaves as a write.
        cyc_drive(1, 1, 12'h030, 4'hF, 32'h1234_5678, 0, 0, '0, '0, '0, 0);
        cyc_drive(1, 0, 12'h030, 4'hF, '0, 0, 0, '0, '0, '0, 0);
        // Read accepted, then reset_req for three contended cycles.
        cyc_drive(1, 0, 12'h010, 4'hF, '0, 0, 0, '0, '0, '0, 0);
        for (int i = 0; i < 3; i++)
            cyc_drive(1, 0, 12'h011, 4'hF, '0, 1, 0, 12'h012, 4'hF, '0, 1);
        idle(0);
        // Build some contention, accept a read, then reset before its return.
        cyc_drive(1, 0, 12'h005, 4'hF, '0, 1, 0, 12'h006, 4'hF, '0, 0);
        cyc_drive(1, 0, 12'h007, 4'hF, '0, 0, 0, '0, '0, '0, 0);
        mid_reset();
        cyc_drive(1, 0, 12'h008, 4'hF, '0, 1, 0, 12'h009, 4'hF, '0, 0);
        rst_next = 1'b0;
        cyc_drive(1, 0, 12'h00A, 4'hF, '0, 1, 0, 12'h00B, 4'hF, '0, 0);
        cyc_drive(1, 0, 12'h00C, 4'hF, '0, 1, 0, 12'h00D, 4'hF, '0, 0);
        // Randomized traffic on a small address window (plus the top of memory).
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a0, a1;
            a0 = 12'($urandom_range(0, 15)) | (($urandom % 2) ? 12'hFF0 : 12'h000);
            a1 = 12'($urandom_range(0, 15)) | (($urandom % 2) ? 12'hFF0 : 12'h000);
            cyc_drive(($urandom % 3) == 0, ($urandom % 4) == 0, a0, 4'($urandom), $urandom,
                      ($urandom % 3) == 0, ($urandom % 4) == 0, a1, 4'($urandom), $urandom,
                      ($urandom % 10) == 0);
        end
        for (int i = 0; i < 3; i++) idle(0);
        chk("drain_rr", 0, q_rr.size(), 0);
        chk("drain_fp", 1, q_fp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
